// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device-generated clock edges.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6500,
  parameter int unsigned TIMEOUT_CYCLES = 1_300_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fe_c;

  logic [2:0]    state, state_n;
  logic [7:0]    data_q, data_q_n;
  logic          parity_q, parity_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          ack_q, ack_n;
  logic          clk_oe_n, data_oe_n, busy_n, done_n, ack_ok_n, err_n;
  logic          to_active_c, to_hit_c;

  // Pad synchronizers; reset to the idle (released, high) bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fe_c = clk_prev & ~clk_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ack_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      data_q      <= data_q_n;
      parity_q    <= parity_n;
      bit_cnt     <= bit_cnt_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      ack_q       <= ack_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      ack_ok      <= ack_ok_n;
      err_timeout <= err_n;
    end
  end

  assign to_active_c = (state == S_REQ) || (state == S_SEND) ||
                       (state == S_ACK) || (state == S_WAIT);
  assign to_hit_c    = to_cnt >= TW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_n   = state;
    data_q_n  = data_q;
    parity_n  = parity_q;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    ack_n     = ack_q;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    ack_ok_n  = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        // The done cycle is still part of the previous transfer.
        if (tx_start && !done) begin
          data_q_n  = tx_data;
          parity_n  = ~^tx_data;
          bit_cnt_n = '0;
          inh_cnt_n = '0;
          to_cnt_n  = '0;
          ack_n     = 1'b0;
          clk_oe_n  = 1'b1;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt != IW'(INHIBIT_CYCLES)) inh_cnt_n = inh_cnt + IW'(1);
        if (inh_cnt >= IW'(INHIBIT_CYCLES - 1)) begin
          data_oe_n = 1'b1;
          state_n   = S_REQ;
        end
      end
      S_REQ: begin
        clk_oe_n = 1'b0;
        state_n  = S_SEND;
      end
      S_SEND: begin
        if (fe_c) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_n = ~data_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_n = ~parity_q;
          end else begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fe_c) begin
          ack_n   = ~data_sync;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (clk_sync && data_sync) begin
          done_n   = 1'b1;
          ack_ok_n = ack_q;
          state_n  = S_IDLE;
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase

    // Abort on timeout unless a normal completion lands in the same cycle.
    if (to_active_c) begin
      if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt_n = to_cnt + TW'(1);
      if (to_hit_c && !done_n) begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        done_n    = 1'b1;
        ack_ok_n  = 1'b0;
        err_n     = 1'b1;
        state_n   = S_IDLE;
      end
    end

    busy_n = (state_n != S_IDLE) || done_n;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the pads.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, ack_ok, err_timeout;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_in, ps2_data_in;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // One transfer with the device answering on the pads.
  task automatic xfer(input string nm, input logic [7:0] b, input bit give_ack,
                      input int glitch_at, input int rst_at, input logic [9:0] exp_bits);
    logic [9:0] bits;
    int n;
    tx_data  = b;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check({nm, "_accept"}, 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'(3'b110));
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < INH * 4) begin
      step();
      n++;
    end
    check({nm, "_inhibit_len"}, 32'(n), 32'(INH));
    check({nm, "_clk_held"}, 32'(ps2_clk_oe), 32'(1));
    step();
    check({nm, "_req"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b01));
    bits = '0;
    for (int i = 1; i <= 11; i++) begin
      repeat (H) step();
      dev_clk_low = 1'b1;
      if (i == glitch_at) begin
        step();
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (H - 2) step();
      end else begin
        repeat (H) step();
      end
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_data_in;
      if (i == 10 && give_ack) dev_data_low = 1'b1;
      if (i == 11) dev_data_low = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({nm, "_rst_release"}, 32'({ps2_clk_oe, ps2_data_oe, busy, done}), 32'(0));
        n = 0;
        repeat (60) begin
          step();
          if (done) n++;
        end
        check({nm, "_rst_no_done"}, 32'(n), 32'(0));
        return;
      end
    end
    check({nm, "_bits"}, 32'(bits), 32'(exp_bits));
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({nm, "_done"}, 32'(done), 32'(1));
    check({nm, "_ack_err"}, 32'({ack_ok, err_timeout}), 32'({give_ack, 1'b0}));
    check({nm, "_busy_in_done"}, 32'(busy), 32'(1));
    step();
    check({nm, "_after"}, 32'({busy, done, ack_ok, ps2_clk_oe, ps2_data_oe}), 32'(0));
  endtask

  initial begin
    int n, m;
    rst          = 1'b1;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) step();
    check("reset_outputs",
          32'({busy, done, ack_ok, err_timeout, ps2_clk_oe, ps2_data_oe}), 32'(0));
    rst = 1'b0;

    // LSB first, then parity, then stop.
    xfer("f4",   8'hF4, 1'b1, 0, 0, 10'b1_0_11110100);
    xfer("00",   8'h00, 1'b1, 0, 0, 10'b1_1_00000000);
    xfer("ff",   8'hFF, 1'b1, 0, 0, 10'b1_1_11111111);
    xfer("nack", 8'hF4, 1'b0, 0, 0, 10'b1_0_11110100);
    xfer("busy_start", 8'hA5, 1'b1, 3, 0, 10'b1_1_10100101);

    // Device never clocks.
    tx_data  = 8'h55;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < INH * 4) begin
      step();
      n++;
    end
    check("to_inhibit_len", 32'(n), 32'(INH));
    m = 0;
    while (done !== 1'b1 && m < TO + 100) begin
      step();
      m++;
    end
    check("to_latency", 32'(m), 32'(TO));
    check("to_flags", 32'({done, ack_ok, err_timeout}), 32'(3'b101));
    step();
    check("to_after", 32'({ps2_clk_oe, ps2_data_oe, busy, done, err_timeout}), 32'(0));

    xfer("rst_mid", 8'hC3, 1'b1, 0, 4, 10'b0);
    xfer("post_rst", 8'h5A, 1'b1, 0, 0, 10'b1_1_01011010);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xF4 "enable data reporting" or 0xFF "reset", to the mouse over the same open-collector ps2_clk/ps2_data pair that the mouse receiver reads. It sits beside the mouse controller in the top level. While it transmits it owns the bus and asserts busy; the receiver ignores the line while busy is high.

## Interface
Parameters:
- INHIBIT_CYCLES, default 6500: clock-low inhibit time in clk cycles (100 µs at 65 MHz).
- TIMEOUT_CYCLES, default 1_300_000: abort limit in clk cycles, counted from clock release to completion (20 ms at 65 MHz).

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- tx_data, in, 8: byte to send; sampled on an accepted tx_start.
- tx_start, in, 1: one-cycle start request.
- busy, out, 1: high from the accepted start until the cycle after done.
- done, out, 1: one-cycle pulse when a transfer finishes or aborts.
- ack_ok, out, 1: valid while done is high; 1 means the device acknowledged.
- err_timeout, out, 1: one-cycle pulse, coincident with done, on timeout.
- ps2_clk_in, in, 1: raw pad level of ps2_clk.
- ps2_data_in, in, 1: raw pad level of ps2_data.
- ps2_clk_oe, out, 1: 1 pulls ps2_clk low; 0 releases it. The top level drives the pad to 0 when this is 1 and to z otherwise.
- ps2_data_oe, out, 1: same scheme for ps2_data.

## Operation
- Both pad inputs pass through a 2-FF synchronizer.
- A falling edge (fe) is detected when the previous synchronized clock is 1 and the current one is 0.
- States and transitions:
  - IDLE: both oe = 0. If tx_start is high, latch tx_data, compute parity = ~^tx_data (odd parity), clear the counters, and go to INHIBIT.
  - INHIBIT: ps2_clk_oe = 1. After INHIBIT_CYCLES cycles, set ps2_data_oe = 1 (start bit = 0) and go to REQ.
  - REQ: hold for exactly 1 cycle. Release ps2_clk_oe, keep ps2_data_oe = 1, start the timeout counter, and go to SEND.
  - SEND: on each fe, with bit index n counted from 1:
    - n = 1..8: ps2_data_oe = ~tx_data[n-1], LSB first.
    - n = 9: ps2_data_oe = ~parity.
    - n = 10: ps2_data_oe = 0 (stop bit released high); go to ACK.
  - ACK: on the next fe, record ack = ~data_sync and go to WAIT_IDLE.
  - WAIT_IDLE: when clk_sync and data_sync are both 1, pulse done with ack_ok = ack, then go to IDLE.
- Timeout: in REQ, SEND, ACK, or WAIT_IDLE, once the counter reaches TIMEOUT_CYCLES:
  - release both oe;
  - pulse done with ack_ok = 0 and err_timeout = 1;
  - go to IDLE.
- tx_start is ignored when the block is not in IDLE, including the done cycle.
- Counter widths are $clog2(param+1). Neither counter wraps; each saturates at its terminal value.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, ack_ok = 0, err_timeout = 0. State is IDLE and all counters are 0.
- Reset mid-transfer releases both lines in the cycle after rst is sampled high. No done pulse is produced.
- Outputs change the cycle after an accepted tx_start:
  - ps2_clk_oe rises;
  - busy rises.
- ps2_data_oe asserts INHIBIT_CYCLES cycles after ps2_clk_oe asserts.
- ps2_clk_oe deasserts 1 cycle after ps2_data_oe asserts.
- A data update appears on ps2_data_oe 3 clk cycles after the pad falling edge: 2 synchronizer stages plus 1 edge register.
- done, ack_ok and err_timeout are registered and last exactly 1 cycle. busy falls in the cycle after done.
- If timeout and a normal completion occur in the same cycle, the completion takes precedence (ack_ok = ack, err_timeout = 0).
- All outputs are registered; there are no combinational paths from the pad inputs to the outputs.

## Test plan
- Reset: hold rst for 5 cycles, then release -> all outputs 0, and tx_start is accepted on the first cycle after reset.
- Send 0xF4 to a behavioural device model that clocks at 12.5 kHz and drives ack low:
  - captured bits: 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - response: done = 1, ack_ok = 1;
  - timing: ps2_clk_oe held exactly INHIBIT_CYCLES before ps2_data_oe asserts.
- Send 0x00 -> parity bit captured as 1. Send 0xFF -> parity bit captured as 1. Both end with ack_ok = 1.
- NACK: the device leaves data high at the 11th falling edge -> done = 1, ack_ok = 0, err_timeout = 0.
- Timeout and start-while-busy:
  - device never clocks -> err_timeout = 1 and done = 1 exactly TIMEOUT_CYCLES after REQ, and both oe are 0 the next cycle;
  - a tx_start pulse during SEND -> ignored, and the byte in flight is unchanged.
- Reset during SEND after 4 bits -> both oe = 0 the next cycle, no done pulse, and a following transfer completes normally.
